// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the instruction fetch stage and its helpers:
//   - fetch FSM state encoding (2-bit enum)
//   - instruction-register field positions (opcode, rs, rt, rd, funct, imm16)
//   - PC increment per fetched word
//   - word-alignment helper for PC redirect targets
// ---------------------------------------------------------------------------
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ERR   = 2'd3
   } fetch_state_t;

   localparam int OPC_MSB   = 31;
   localparam int OPC_LSB   = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;

   localparam logic [31:0] PC_STEP = 32'd4;

   // Instructions are word aligned, so redirect targets drop their byte offset.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ir_field_split.sv
// ---------------------------------------------------------------------------
// ir_field_split
// Purely combinational slicer that breaks a 32-bit instruction word into its
// decode fields. Shared between the fetch stage and the decode bench.
// Ports:
//   ir      in  32  instruction word
//   opcode  out 6   ir[31:26]
//   rs      out 5   ir[25:21]
//   rt      out 5   ir[20:16]
//   rd      out 5   ir[15:11]
//   funct   out 6   ir[5:0]
//   imm16   out 16  ir[15:0]
// ---------------------------------------------------------------------------
module ir_field_split
   import instr_fetch_unit_pkg::*;
(
   input  logic [31:0] ir,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [5:0]  funct,
   output logic [15:0] imm16
);

   assign opcode = ir[OPC_MSB:OPC_LSB];
   assign rs     = ir[RS_MSB:RS_LSB];
   assign rt     = ir[RT_MSB:RT_LSB];
   assign rd     = ir[RD_MSB:RD_LSB];
   assign funct  = ir[FUNCT_MSB:FUNCT_LSB];
   assign imm16  = ir[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Upstream stage of microctrl. Fetches 32-bit instructions over a req/ack
// memory port into the instruction register (IR) and presents the decoded
// IR fields plus the PC. After reset a boot fetch starts on its own; later
// fetches are requested by microctrl through fetch_start. A fetch that sees
// no mem_ack for TIMEOUT cycles raises a sticky fetch_err and parks the unit
// until reset (TIMEOUT = 0 disables the limit).
// Ports:
//   clk          in  1   system clock, rising edge
//   rst          in  1   asynchronous reset, active low
//   fetch_start  in  1   request next fetch (used only while holding)
//   pc_load      in  1   load pc from pc_next (used only while holding)
//   pc_next      in  32  redirect target, byte offset dropped on load
//   mem_req      out 1   registered memory read request
//   mem_addr     out 32  read address (the pc)
//   mem_ack      in  1   read data valid (used only while fetching)
//   mem_rdata    in  32  instruction word
//   opcode       out 6   IR[31:26]
//   rs/rt/rd     out 5   IR[25:21]/IR[20:16]/IR[15:11]
//   funct        out 6   IR[5:0]
//   imm16        out 16  IR[15:0]
//   ir_valid     out 1   IR holds a fetched, unconsumed instruction
//   pc           out 32  address of the next fetch
//   fetch_err    out 1   sticky fetch timeout flag
// ---------------------------------------------------------------------------
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          TIMEOUT  = 15
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic        pc_load,
   input  logic [31:0] pc_next,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic        ir_valid,
   output logic [31:0] pc,
   output logic        fetch_err
);

   // With TIMEOUT = 0 this value is never used, the limit check is disabled.
   localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);

   fetch_state_t state, state_nxt;

   logic [31:0] pc_q, pc_nxt;
   logic [31:0] ir_q, ir_nxt;
   logic [31:0] timer_q, timer_nxt;
   logic        mem_req_q, mem_req_nxt;
   logic        ir_valid_q, ir_valid_nxt;
   logic        err_q, err_nxt;

   // State register. Reset parks the FSM in BOOT so the first edge after
   // release launches the boot fetch without any request from microctrl.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-register logic. mem_req is computed one cycle ahead
   // so the request leaves the unit straight from a flop. The PC only moves on
   // an accepted word or a redirect while holding; during a bus transaction it
   // stays frozen so mem_addr cannot change under an outstanding request.
   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc_q;
      ir_nxt       = ir_q;
      timer_nxt    = timer_q;
      mem_req_nxt  = 1'b0;
      ir_valid_nxt = ir_valid_q;
      err_nxt      = err_q;

      case (state)
         ST_BOOT: begin
            state_nxt    = ST_FETCH;
            mem_req_nxt  = 1'b1;
            ir_valid_nxt = 1'b0;
            timer_nxt    = '0;
         end

         ST_FETCH: begin
            ir_valid_nxt = 1'b0;
            if (mem_ack) begin
               ir_nxt       = mem_rdata;
               pc_nxt       = pc_q + PC_STEP;
               ir_valid_nxt = 1'b1;
               timer_nxt    = '0;
               state_nxt    = ST_HOLD;
            end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
               err_nxt   = 1'b1;
               state_nxt = ST_ERR;
            end else begin
               timer_nxt   = timer_q + 32'd1;
               mem_req_nxt = 1'b1;
            end
         end

         ST_HOLD: begin
            // A redirect on the same edge as fetch_start is picked up by the
            // new fetch, since mem_addr reads the freshly loaded pc.
            if (pc_load) begin
               pc_nxt = align_word(pc_next);
            end
            if (fetch_start) begin
               state_nxt    = ST_FETCH;
               ir_valid_nxt = 1'b0;
               mem_req_nxt  = 1'b1;
               timer_nxt    = '0;
            end
         end

         ST_ERR: begin
            ir_valid_nxt = 1'b0;
            err_nxt      = 1'b1;
         end

         default: begin
            state_nxt = ST_BOOT;
         end
      endcase
   end

   // Datapath registers. Asynchronous reset drops mem_req immediately and
   // clears IR so opcode reads zero while reset is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= PC_RESET;
         ir_q       <= '0;
         timer_q    <= '0;
         mem_req_q  <= 1'b0;
         ir_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         pc_q       <= pc_nxt;
         ir_q       <= ir_nxt;
         timer_q    <= timer_nxt;
         mem_req_q  <= mem_req_nxt;
         ir_valid_q <= ir_valid_nxt;
         err_q      <= err_nxt;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = pc_q;
   assign pc        = pc_q;
   assign ir_valid  = ir_valid_q;
   assign fetch_err = err_q;

   ir_field_split u_split (
      .ir     (ir_q),
      .opcode (opcode),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd),
      .funct  (funct),
      .imm16  (imm16)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. Inputs change and outputs are
// sampled on the falling clock edge. A small reference model (pc, IR, valid,
// error flag) tracks what the fetch unit should show.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic        pc_load;
   logic [31:0] pc_next;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic        ir_valid;
   logic [31:0] pc;
   logic        fetch_err;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] model_pc;
   logic [31:0] model_ir;
   logic        model_valid;
   logic        model_err;

   typedef struct {
      logic        load;
      logic [31:0] target;
      int          delay;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
   } fetch_vec_t;

   fetch_vec_t tbl[4];

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .PC_RESET (32'h0000_0000),
      .TIMEOUT  (15)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_start (fetch_start),
      .pc_load     (pc_load),
      .pc_next     (pc_next),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .opcode      (opcode),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .funct       (funct),
      .imm16       (imm16),
      .ir_valid    (ir_valid),
      .pc          (pc),
      .fetch_err   (fetch_err)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic fs, input logic pl, input logic [31:0] pn,
                                input logic ack, input logic [31:0] rdata);
      fetch_start = fs;
      pc_load     = pl;
      pc_next     = pn;
      mem_ack     = ack;
      mem_rdata   = rdata;
   endtask

   // Compare every output against the model while no request is in flight.
   task automatic checkIdle(input string tag);
      checkOutput({tag, " mem_req"},   32'(mem_req),   32'd0);
      checkOutput({tag, " ir_valid"},  32'(ir_valid),  32'(model_valid));
      checkOutput({tag, " fetch_err"}, 32'(fetch_err), 32'(model_err));
      checkOutput({tag, " pc"},        pc,             model_pc);
      checkOutput({tag, " opcode"},    32'(opcode),    32'(model_ir[31:26]));
      checkOutput({tag, " rs"},        32'(rs),        32'(model_ir[25:21]));
      checkOutput({tag, " rt"},        32'(rt),        32'(model_ir[20:16]));
      checkOutput({tag, " rd"},        32'(rd),        32'(model_ir[15:11]));
      checkOutput({tag, " funct"},     32'(funct),     32'(model_ir[5:0]));
      checkOutput({tag, " imm16"},     32'(imm16),     32'(model_ir[15:0]));
   endtask

   // Hold reset low for one cycle, check the reset image, release it.
   // Returns at the first falling edge with the boot fetch in progress.
   task automatic doReset();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      model_pc    = 32'h0000_0000;
      model_ir    = 32'd0;
      model_valid = 1'b0;
      model_err   = 1'b0;
      @(negedge clk);
      checkIdle("reset");
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Drive a fetch that is already requesting: ack arrives after 'delay'
   // waiting cycles. Stray fetch_start/pc_load are thrown in and must be
   // ignored. Ends one cycle after the ack edge.
   task automatic runFetch(input int delay, input logic [31:0] rdata);
      for (int c = 0; c <= delay; c++) begin
         checkOutput("fetch mem_req",  32'(mem_req),  32'd1);
         checkOutput("fetch mem_addr", mem_addr,      model_pc);
         checkOutput("fetch ir_valid", 32'(ir_valid), 32'd0);
         checkOutput("fetch opcode held", 32'(opcode), 32'(model_ir[31:26]));
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                       (c == delay), (c == delay) ? rdata : $urandom);
         @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      model_ir    = rdata;
      model_pc    = model_pc + 32'd4;
      model_valid = 1'b1;
      checkIdle("after ack");
   endtask

   // From HOLD: request a fetch, optionally redirecting on the same edge.
   task automatic startFetch(input logic load, input logic [31:0] target);
      applyStimulus(1'b1, load, target, 1'($urandom_range(0, 1)), $urandom);
      @(negedge clk);
      if (load) model_pc = target & 32'hFFFF_FFFC;
      model_valid = 1'b0;
   endtask

   // Idle cycles in HOLD with stray acks: nothing may change.
   task automatic holdIdle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom);
         @(negedge clk);
         checkIdle("hold idle");
      end
   endtask

   task automatic redirectOnly(input logic [31:0] target);
      applyStimulus(1'b0, 1'b1, target, 1'($urandom_range(0, 1)), $urandom);
      @(negedge clk);
      model_pc = target & 32'hFFFF_FFFC;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      checkIdle("redirect");
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Redirect/fetch table: expected addresses and PCs worked out by hand.
      tbl[0] = '{1'b1, 32'h0000_0103, 0, 32'h2000_0000, 32'h0000_0100, 32'h0000_0104};
      tbl[1] = '{1'b0, 32'h0000_0000, 3, 32'h8C22_0010, 32'h0000_0104, 32'h0000_0108};
      tbl[2] = '{1'b1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
      tbl[3] = '{1'b0, 32'h0000_0000, 2, 32'h0123_4567, 32'h0000_0000, 32'h0000_0004};

      // Boot fetch with zero-wait memory.
      doReset();
      runFetch(0, 32'h0800_0004);
      checkOutput("boot opcode", 32'(opcode), 32'h0000_0002);
      checkOutput("boot pc",     pc,          32'h0000_0004);
      holdIdle(2);

      // Table-driven fetches, including redirect+fetch on one edge and wrap.
      for (int i = 0; i < 4; i++) begin
         startFetch(tbl[i].load, tbl[i].target);
         checkOutput("table first addr", mem_addr, tbl[i].exp_addr);
         runFetch(tbl[i].delay, tbl[i].rdata);
         checkOutput("table pc after", pc, tbl[i].exp_pc);
         checkOutput("table opcode", 32'(opcode), 32'(tbl[i].rdata[31:26]));
         holdIdle(1);
      end

      // Randomized mix of idles, redirects and fetches.
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 2))
            0: holdIdle(int'($urandom_range(1, 3)));
            1: redirectOnly($urandom);
            default: begin
               startFetch(1'($urandom_range(0, 1)), $urandom);
               runFetch(int'($urandom_range(0, 6)), $urandom);
            end
         endcase
      end

      // Timeout: no ack for 15 FETCH cycles.
      startFetch(1'b0, 32'd0);
      for (int c = 0; c < 15; c++) begin
         checkOutput("timeout mem_req",   32'(mem_req),   32'd1);
         checkOutput("timeout fetch_err", 32'(fetch_err), 32'd0);
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                       1'b0, $urandom);
         @(negedge clk);
      end
      model_err   = 1'b1;
      model_valid = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      checkIdle("timeout");
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 1'b1, $urandom, 1'b1, $urandom);
         @(negedge clk);
         checkIdle("err locked");
      end

      // Reset out of ERR, then an asynchronous reset in the middle of a fetch.
      doReset();
      runFetch(1, $urandom);
      startFetch(1'b1, 32'h0000_0040);
      checkOutput("pre-reset mem_req",  32'(mem_req), 32'd1);
      checkOutput("pre-reset mem_addr", mem_addr,     32'h0000_0040);
      #2;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1;
      model_pc    = 32'h0000_0000;
      model_ir    = 32'd0;
      model_valid = 1'b0;
      model_err   = 1'b0;
      checkIdle("async reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      runFetch(2, $urandom);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
